// File: rtl/graph_mem_arbiter_pkg.sv
// Shared types and defaults for the graph memory read-port arbiter.
// rr_pick is the reference rotate-and-pick used when sizes match the defaults.
package graph_arb_pkg;

  localparam int ARB_NUM_REQ     = 4;
  localparam int ARB_ADDR_W      = 32;
  localparam int ARB_DATA_W      = 32;
  localparam int ARB_MEM_LATENCY = 2;
  localparam int ARB_MAX_LOCK    = 4;
  localparam int ARB_ID_W        = $clog2(ARB_NUM_REQ);

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] id;
  } tag_t;

  // First valid requester at or after ptr, wrapping; returns a one-hot grant.
  function automatic logic [ARB_NUM_REQ-1:0] rr_pick(
    input logic [ARB_NUM_REQ-1:0] valid,
    input logic [ARB_ID_W-1:0]    ptr
  );
    logic [ARB_NUM_REQ-1:0] grant;
    logic                   found;
    int                     idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % ARB_NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/graph_mem_arbiter_if.sv
// Requester, response and memory-port bundle of graph_mem_arbiter.
// Handshake: a request transfers in a cycle where req_valid_in[i] & req_ready_out[i]; the
// requester keeps valid/addr stable until then; responses are one-shot pulses with no back-pressure.
interface graph_mem_arbiter_if
  import graph_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W
);

  logic [NUM_REQ-1:0]             req_valid_in;
  logic [NUM_REQ-1:0]             req_lock_in;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ-1:0]             req_ready_out;
  logic [DATA_W-1:0]              resp_data_out;
  logic [NUM_REQ-1:0]             resp_valid_out;
  logic [ADDR_W-1:0]              mem_addr_out;
  logic                           mem_valid_out;
  logic [DATA_W-1:0]              mem_data_in;
  logic                           mem_valid_in;
  logic                           err_out;
  arb_state_t                     dbg_state;
  logic [$clog2(NUM_REQ)-1:0]     dbg_owner;

  modport slave (
    input  req_valid_in, req_lock_in, req_addr_in, mem_data_in, mem_valid_in,
    output req_ready_out, resp_data_out, resp_valid_out, mem_addr_out, mem_valid_out,
    output err_out, dbg_state, dbg_owner
  );

  modport master (
    output req_valid_in, req_lock_in, req_addr_in, mem_data_in, mem_valid_in,
    input  req_ready_out, resp_data_out, resp_valid_out, mem_addr_out, mem_valid_out,
    input  err_out, dbg_state, dbg_owner
  );

endinterface

// File: rtl/graph_mem_arbiter_pick.sv
// Combinational rotate-and-pick: one-hot grant to the first valid requester from i_ptr upward.
module rr_priority_pick
  import graph_arb_pkg::*;
#(
  parameter int N  = ARB_NUM_REQ,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  generate
    if (N == ARB_NUM_REQ && PW == ARB_ID_W) begin : g_pkg
      assign o_grant = rr_pick(i_valid, i_ptr);
    end else begin : g_generic
      logic w_found;
      int   w_idx;
      always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
          w_idx = (int'(i_ptr) + k) % N;
          if (!w_found && i_valid[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing one graph_memory read port, with optional grant lock and tag-routed
// responses. Define ARB_STATS_EN to add per-requester grant and stall counters.
module graph_mem_arbiter
  import graph_arb_pkg::*;
#(
  parameter int NUM_REQ     = ARB_NUM_REQ,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int MEM_LATENCY = ARB_MEM_LATENCY,
  parameter int MAX_LOCK    = ARB_MAX_LOCK
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ-1:0][31:0]  grant_cnt_out,
  output logic [NUM_REQ-1:0][31:0]  stall_cnt_out,
`endif
  graph_mem_arbiter_if.slave        bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int LCW  = $clog2(MAX_LOCK + 1);
  localparam int TAIL = MEM_LATENCY;

  arb_state_t         r_state;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [LCW-1:0]     r_lock_cnt;

  logic [NUM_REQ-1:0] w_pick;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_accept;
  logic               w_lock_hold;

  logic               r_mem_valid;
  logic [ADDR_W-1:0]  r_mem_addr;
  tag_t               r_tag [TAIL+1];
  logic               w_tail_hit;
  logic [NUM_REQ-1:0] w_resp_oh;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_err;

  rr_priority_pick #(.N(NUM_REQ), .PW(ID_W)) u_pick (
    .i_valid (bus.req_valid_in),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick)
  );

  // While locked, only the owner may win, even in cycles where it is not requesting.
  always_comb begin
    w_grant = '0;
    if (r_state == ARB_LOCKED) begin
      w_grant[r_owner] = bus.req_valid_in[r_owner];
    end else begin
      w_grant = w_pick;
    end
  end

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gnt_id = ID_W'(i);
    end
  end

  assign w_accept    = |w_grant;
  assign w_lock_hold = bus.req_lock_in[w_gnt_id] && ((int'(r_lock_cnt) + 1) < MAX_LOCK);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ARB_UNLOCKED;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_lock_cnt <= '0;
    end else if (w_accept) begin
      if (w_lock_hold) begin
        r_state    <= ARB_LOCKED;
        r_owner    <= w_gnt_id;
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end else begin
        // Plain release and the forced release at MAX_LOCK both land here.
        r_state    <= ARB_UNLOCKED;
        r_lock_cnt <= '0;
        r_rr_ptr   <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_mem_valid <= w_accept;
      if (w_accept) r_mem_addr <= bus.req_addr_in[w_gnt_id];
    end
  end

  // Stage 0 lines up with mem_valid_out, so the tail lines up with mem_valid_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s <= TAIL; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= tag_t'{valid: w_accept, id: ARB_ID_W'(w_gnt_id)};
      for (int s = 1; s <= TAIL; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_tail_hit = bus.mem_valid_in & r_tag[TAIL].valid;

  always_comb begin
    w_resp_oh = '0;
    w_resp_oh[r_tag[TAIL].id] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= w_tail_hit ? w_resp_oh : '0;
      if (w_tail_hit) r_resp_data <= bus.mem_data_in;
      if (bus.mem_valid_in && !r_tag[TAIL].valid) r_err <= 1'b1;
    end
  end

  assign bus.req_ready_out  = w_grant;
  assign bus.mem_valid_out  = r_mem_valid;
  assign bus.mem_addr_out   = r_mem_addr;
  assign bus.resp_valid_out = r_resp_valid;
  assign bus.resp_data_out  = r_resp_data;
  assign bus.err_out        = r_err;
  assign bus.dbg_state      = r_state;
  assign bus.dbg_owner      = r_owner;

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] r_grant_cnt;
  logic [NUM_REQ-1:0][31:0] r_stall_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && (r_grant_cnt[i] != 32'hFFFF_FFFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        if (bus.req_valid_in[i] && !w_grant[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF))
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
      end
    end
  end

  assign grant_cnt_out = r_grant_cnt;
  assign stall_cnt_out = r_stall_cnt;
`endif

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Self-checking bench for graph_mem_arbiter: expected grant order per scenario, a fixed-latency
// memory model, and a response scoreboard keyed on accept cycle, owner and data.
module tb_graph_mem_arbiter;
  import graph_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int ML = 4;
  localparam int QW = 72;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic spur = 1'b0;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;

  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] mon_e;

  logic [N-1:0]  v_valid;
  logic [N-1:0]  v_lock;
  logic [N-1:0]  lock_en;
  logic [AW-1:0] v_addr [N];
  int            rem [N];
  logic          pend_v;
  logic [AW-1:0] pend_addr;

  logic          mv_pipe [L];
  logic [AW-1:0] ma_pipe [L];

  graph_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef ARB_STATS_EN
  logic [N-1:0][31:0] grant_cnt;
  logic [N-1:0][31:0] stall_cnt;
`endif

  graph_mem_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L), .MAX_LOCK(ML)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
`ifdef ARB_STATS_EN
    .grant_cnt_out (grant_cnt),
    .stall_cnt_out (stall_cnt),
`endif
    .bus           (bus)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        mv_pipe[k] <= 1'b0;
        ma_pipe[k] <= '0;
      end
    end else begin
      mv_pipe[0] <= bus.mem_valid_out;
      ma_pipe[0] <= bus.mem_addr_out;
      for (int k = 1; k < L; k++) begin
        mv_pipe[k] <= mv_pipe[k-1];
        ma_pipe[k] <= ma_pipe[k-1];
      end
    end
  end

  assign bus.mem_valid_in = mv_pipe[L-1] | spur;
  assign bus.mem_data_in  = mem_f(ma_pipe[L-1]);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_checks(input string t);
    chk({t, "_ready"},      64'(bus.req_ready_out),  64'd0);
    chk({t, "_resp_valid"}, 64'(bus.resp_valid_out), 64'd0);
    chk({t, "_resp_data"},  64'(bus.resp_data_out),  64'd0);
    chk({t, "_mem_valid"},  64'(bus.mem_valid_out),  64'd0);
    chk({t, "_mem_addr"},   64'(bus.mem_addr_out),   64'd0);
    chk({t, "_err"},        64'(bus.err_out),        64'd0);
    chk({t, "_state"},      64'(bus.dbg_state),      64'(ARB_UNLOCKED));
  endtask

  // ---------------- driver ----------------
  task automatic apply();
    bus.req_valid_in = v_valid;
    bus.req_lock_in  = v_lock;
    for (int k = 0; k < N; k++) bus.req_addr_in[k] = v_addr[k];
  endtask

  task automatic refresh(input int i);
    v_valid[i] = (rem[i] > 0);
    v_lock[i]  = lock_en[i] && (rem[i] > 1);
  endtask

  // One clock: check issue of last cycle's accept, check grant, score accepts, drive next inputs.
  task automatic cycle(input int exp_gnt);
    logic [N-1:0] acc;
    logic [N-1:0] oh;
    @(negedge clk);
    chk("mem_valid", 64'(bus.mem_valid_out), 64'(pend_v));
    if (pend_v) chk("mem_addr", 64'(bus.mem_addr_out), 64'(pend_addr));
    oh = '0;
    if (exp_gnt >= 0) oh[exp_gnt] = 1'b1;
    chk($sformatf("grant@%0d", cyc), 64'(bus.req_ready_out), 64'(oh));
    acc    = bus.req_ready_out & bus.req_valid_in;
    pend_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        pend_v    = 1'b1;
        pend_addr = v_addr[i];
        exp_q.push_back({32'(cyc + L + 2), 8'(1 << i), mem_f(v_addr[i])});
        rem[i]--;
        v_addr[i] = $urandom;
        refresh(i);
      end
    end
    @(posedge clk);
    #1;
    apply();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus.resp_valid_out != '0) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(bus.resp_valid_out), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_owner", 64'(bus.resp_valid_out), 64'(mon_e[39:32]));
        chk("resp_data",  64'(bus.resp_data_out),  64'(mon_e[31:0]));
        chk("resp_cycle", 64'(cyc),                64'(mon_e[71:40]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    v_valid = '0;
    v_lock  = '0;
    lock_en = '0;
    for (int k = 0; k < N; k++) begin
      v_addr[k] = '0;
      rem[k]    = 0;
    end
    pend_v    = 1'b0;
    pend_addr = '0;
    apply();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // all four requesting, no lock: strict rotation
    for (int i = 0; i < N; i++) begin
      rem[i]    = 2;
      v_addr[i] = $urandom;
      refresh(i);
    end
    apply();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) cycle(i);
    repeat (6) cycle(-1);

    // single requester 1 at address 0x10
    v_addr[1] = 32'h10;
    rem[1]    = 1;
    refresh(1);
    apply();
    cycle(1);
    repeat (6) cycle(-1);

    // requester 2 locks for 6 requests: forced release after MAX_LOCK grants
    lock_en[2] = 1'b1;
    rem[2]     = 6;
    v_addr[2]  = $urandom;
    refresh(2);
    apply();
    cycle(2);
    rem[0]    = 1;
    rem[3]    = 1;
    v_addr[0] = $urandom;
    v_addr[3] = $urandom;
    refresh(0);
    refresh(3);
    apply();
    cycle(2);
    cycle(2);
    cycle(2);
    cycle(3);
    cycle(0);
    cycle(2);
    cycle(2);
    lock_en[2] = 1'b0;
    repeat (6) cycle(-1);

    // locked requester 1 goes idle; requester 0 must wait
    lock_en[1] = 1'b1;
    rem[1]     = 2;
    v_addr[1]  = $urandom;
    refresh(1);
    apply();
    cycle(1);
    v_valid[1] = 1'b0;
    rem[0]     = 1;
    v_addr[0]  = $urandom;
    refresh(0);
    apply();
    cycle(-1);
    chk("lock_state", 64'(bus.dbg_state), 64'(ARB_LOCKED));
    chk("lock_owner", 64'(bus.dbg_owner), 64'd1);
    cycle(-1);
    cycle(-1);
    v_valid[1] = 1'b1;
    apply();
    cycle(1);
    cycle(0);
    lock_en[1] = 1'b0;
    repeat (6) cycle(-1);

    // spurious memory data with nothing in flight
    spur = 1'b1;
    @(negedge clk);
    chk("err_before", 64'(bus.err_out), 64'd0);
    @(posedge clk);
    #1;
    spur = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(bus.err_out), 64'd1);
    @(posedge clk);
    #1;
    repeat (3) cycle(-1);
    chk("err_sticky", 64'(bus.err_out), 64'd1);

    // reset one cycle after three accepts: in-flight responses vanish
    rem[3]    = 3;
    v_addr[3] = $urandom;
    refresh(3);
    apply();
    cycle(3);
    cycle(3);
    cycle(3);
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < N; k++) rem[k] = 0;
    v_valid = '0;
    v_lock  = '0;
    apply();
    pend_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_checks("rst1");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rem[1]    = 1;
    rem[2]    = 1;
    v_addr[1] = $urandom;
    v_addr[2] = $urandom;
    refresh(1);
    refresh(2);
    apply();
    cycle(1);
    cycle(2);
    repeat (8) cycle(-1);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/graph_mem_arbiter.md
Name: graph_mem_arbiter

Overview:
Round-robin arbiter that lets NUM_REQ requesters share one read port of graph_memory. Requesters are graph_fetch instances or bfis cores when PROC_BITS>0. It accepts valid/ready read requests and issues at most one registered request per cycle to the memory port. It tracks each in-flight request's owner in a fixed-latency tag pipeline and routes each returned word back to that owner. Optional lock holds the grant for consecutive requests from one requester, e.g. DIM position words of a vertex.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_W, 32, request address width
DATA_W, 32, memory data width
MEM_LATENCY, 2, cycles from mem_valid_out to mem_valid_in (fixed, graph_memory BRAM)
MAX_LOCK, 4, max consecutive grants under lock before forced release (>=1)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
req_valid_in  in  NUM_REQ  per-requester request valid
req_lock_in  in  NUM_REQ  keep grant after this request
req_addr_in  in  NUM_REQ x ADDR_W  per-requester address (packed)
req_ready_out  out  NUM_REQ  one-hot grant; request accepted when valid&ready
resp_data_out  out  DATA_W  returned word, shared by all requesters
resp_valid_out  out  NUM_REQ  one-hot: resp_data_out belongs to this requester
mem_addr_out  out  ADDR_W  address to graph_memory
mem_valid_out  out  1  request strobe to graph_memory
mem_data_in  in  DATA_W  graph_memory read data
mem_valid_in  in  1  graph_memory data valid
err_out  out  1  sticky: mem_valid_in with no tracked request

Behaviour:
- Reset: req_ready_out=0, resp_valid_out=0, resp_data_out=0, mem_valid_out=0, mem_addr_out=0, err_out=0. rr_ptr=0, lock idle, lock_cnt=0, tag pipeline cleared. Responses in flight at reset are dropped.
- req_ready_out is combinational from req_valid_in, rr_ptr and lock state. It is at most one-hot and never asserted without the matching valid. A requester holds valid/addr stable until accepted.
- Arbitration, unlocked: grant the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. After a grant to i with lock=0, rr_ptr<=(i+1) mod NUM_REQ.
- Lock: a grant to i with req_lock_in[i]=1 and lock_cnt+1<MAX_LOCK enters LOCKED(i) and increments lock_cnt.
  - In LOCKED(i), only i may be granted. Other requesters wait even if i is idle that cycle.
  - A grant with lock=0 returns to UNLOCKED, sets lock_cnt=0 and advances rr_ptr.
  - Reaching MAX_LOCK grants forces UNLOCKED and rr_ptr=i+1 regardless of lock.
  - Deasserting req_valid_in[i] while LOCKED does not release the lock.
- Issue: an accepted request at cycle t gives mem_valid_out=1, mem_addr_out=addr at t+1. mem_valid_out=0 in cycles with no grant. Throughput is 1 request/cycle.
- Tag pipeline: MEM_LATENCY+1 stages of {valid, owner id}, shifted every cycle and aligned so the tail matches mem_valid_in.
- Response: when mem_valid_in=1 with tail valid, then at the next cycle resp_valid_out[owner]=1 and resp_data_out=mem_data_in. End-to-end latency is accept t to resp t+MEM_LATENCY+2. resp_data_out holds its last value otherwise.
- mem_valid_in=1 with tail invalid: drop the word and set err_out=1 (sticky until reset).
- Tail valid with mem_valid_in=0: drop the tag; no response, no error.
- Simultaneous accept and response to the same requester is legal, with no interaction.

Optional Feature:
ARB_STATS_EN
- Defined: adds output grant_cnt_out (NUM_REQ x 32) and stall_cnt_out (NUM_REQ x 32).
  - grant_cnt_out counts accepted requests per requester.
  - stall_cnt_out counts cycles with valid=1 and ready=0.
  - Both saturate at 2^32-1 and are cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package graph_arb_pkg:
  - typedef arb_state_t {ARB_UNLOCKED, ARB_LOCKED}
  - typedef tag_t {logic valid; logic [$clog2(NUM_REQ)-1:0] id}
  - function rr_pick(valid, ptr) returning a one-hot grant
- One sub-module, rr_priority_pick: combinational rotate-and-pick used by the arbiter and reusable for the checked_visited port.
- The tag pipeline stays inline.

Test Plan:
- Single requester: req 1 valid, addr=0x10 at t=5; mem returns 0xABCD at t=8 -> mem_valid_out/mem_addr_out=0x10 at t=6; resp_valid_out=4'b0010 with resp_data_out=0xABCD at t=9.
- All 4 requesters valid continuously, lock=0 -> grants 0,1,2,3,0,1,2,3 one per cycle; responses arrive in the same order, each MEM_LATENCY+2 after its accept.
- Req 2 lock=1 for 6 requests, req 0 and req 3 valid -> grants 2,2,2,2 (MAX_LOCK forced release), then 3, 0, then 2.
- Locked requester 1 drops valid for 3 cycles while req 0 is valid -> no grants during those cycles; requester 1 regains the grant when it reasserts.
- Spurious mem_valid_in=1 with the pipeline empty -> err_out=1 next cycle and stays high; resp_valid_out stays 0.
- Reset asserted one cycle after 3 accepts -> no resp_valid_out after reset; outputs at reset values; the first post-reset grant goes to the lowest-index valid requester.
